// File: rtl/irq_ctrl.sv
// Prioritised N-channel interrupt controller: edge/level sensing, masking, in-service tracking.
// Define IRQ_NESTING_EN to let a higher-priority channel preempt one already in service.
module irq_ctrl #(
  parameter int unsigned NUM_IRQ       = 8,
  parameter logic [15:0] VECTOR_BASE   = 16'h0064,
  parameter int unsigned VECTOR_STRIDE = 2,
  localparam int unsigned IDW          = $clog2(NUM_IRQ)
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic [NUM_IRQ-1:0] I_irq,
  input  logic [NUM_IRQ-1:0] I_edge_mode,
  input  logic [NUM_IRQ-1:0] I_mask,
  input  logic               I_irq_enabled,
  input  logic               I_ack,
  input  logic               I_eoi,
  output logic               O_irq_active,
  output logic [IDW-1:0]     O_irq_number,
  output logic [15:0]        O_vector,
  output logic [NUM_IRQ-1:0] O_in_service
);

`ifdef IRQ_NESTING_EN
  localparam bit NestEn = 1'b1;
`else
  localparam bit NestEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e             state_q;
  logic [NUM_IRQ-1:0] prev_q, pend_q, pend_d, in_service_q, in_service_d;
  logic               active_q;
  logic [IDW-1:0]     number_q;
  logic [15:0]        vector_q;

  logic [NUM_IRQ-1:0] edge_set, pending, cand, eoi_clr, ins_after_eoi, ack_hot;
  logic [IDW-1:0]     win_idx;
  logic               win_vld, eligible, frozen_ok, ack_take;
  logic [IDW:0]       ins_low, threshold;
  logic [15:0]        win_vec;

  always_comb begin
    edge_set = I_edge_mode & I_irq & ~prev_q;
    pending  = (I_edge_mode & pend_q) | (~I_edge_mode & I_irq);
    cand     = pending & I_mask & ~in_service_q;

    win_idx = '0;
    win_vld = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_idx = IDW'(i);
        win_vld = 1'b1;
      end
    end

    ins_low = (IDW + 1)'(NUM_IRQ);
    eoi_clr = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (in_service_q[i]) begin
        ins_low    = (IDW + 1)'(i);
        eoi_clr    = '0;
        eoi_clr[i] = 1'b1;
      end
    end

    // Without nesting, anything in service blocks every new request.
    if (NestEn) threshold = ins_low;
    else        threshold = (|in_service_q) ? '0 : (IDW + 1)'(NUM_IRQ);

    eligible  = I_irq_enabled & win_vld & ({1'b0, win_idx} < threshold);
    frozen_ok = I_irq_enabled & pending[number_q] & I_mask[number_q] &
                ~in_service_q[number_q] & ({1'b0, number_q} < threshold);
    win_vec   = 16'(32'(VECTOR_BASE) + 32'(win_idx) * VECTOR_STRIDE);

    ack_take      = (state_q == StReq) & I_ack;
    ack_hot       = NUM_IRQ'(1) << number_q;
    ins_after_eoi = I_eoi ? (in_service_q & ~eoi_clr) : in_service_q;
    in_service_d  = ack_take ? (ins_after_eoi | ack_hot) : ins_after_eoi;
    // A fresh edge in the same cycle as the ack survives the clear.
    pend_d        = (pend_q & ~(ack_take ? ack_hot : '0)) | edge_set;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q      <= StIdle;
      prev_q       <= '0;
      pend_q       <= '0;
      in_service_q <= '0;
      active_q     <= 1'b0;
      number_q     <= '0;
      vector_q     <= VECTOR_BASE;
    end else begin
      prev_q       <= I_irq;
      pend_q       <= pend_d;
      in_service_q <= in_service_d;
      case (state_q)
        StIdle: begin
          if (eligible) begin
            state_q  <= StReq;
            active_q <= 1'b1;
            number_q <= win_idx;
            vector_q <= win_vec;
          end
        end
        StReq: begin
          if (I_ack) begin
            state_q  <= StService;
            active_q <= 1'b0;
          end else if (!frozen_ok) begin
            state_q  <= StIdle;
            active_q <= 1'b0;
          end
        end
        StService: begin
          if (I_eoi && (!NestEn || ins_after_eoi == '0)) begin
            state_q <= StIdle;
          end else if (NestEn && eligible) begin
            state_q  <= StReq;
            active_q <= 1'b1;
            number_q <= win_idx;
            vector_q <= win_vec;
          end
        end
        default: begin
          state_q  <= StIdle;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_irq_active = active_q;
  assign O_irq_number = number_q;
  assign O_vector     = vector_q;
  assign O_in_service = in_service_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic against a
// rule-level reference model.
module tb_irq_ctrl;

  localparam int N      = 8;
  localparam int BASE   = 'h0064;
  localparam int STRIDE = 2;
`ifdef IRQ_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif
  localparam int MIdle = 0, MReq = 1, MSvc = 2;

  logic         I_clk = 1'b0;
  logic         I_reset, I_irq_enabled, I_ack, I_eoi;
  logic [N-1:0] I_irq, I_edge_mode, I_mask;
  logic         O_irq_active;
  logic [2:0]   O_irq_number;
  logic [15:0]  O_vector;
  logic [N-1:0] O_in_service;

  irq_ctrl dut (
    .I_clk         (I_clk),
    .I_reset       (I_reset),
    .I_irq         (I_irq),
    .I_edge_mode   (I_edge_mode),
    .I_mask        (I_mask),
    .I_irq_enabled (I_irq_enabled),
    .I_ack         (I_ack),
    .I_eoi         (I_eoi),
    .O_irq_active  (O_irq_active),
    .O_irq_number  (O_irq_number),
    .O_vector      (O_vector),
    .O_in_service  (O_in_service)
  );

  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit [N-1:0] m_pend, m_prev, m_ins;
  int         m_state, m_num;
  bit         m_act;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [N-1:0] v);
    int r = N;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Advance one clock: model computes next state from the inputs, then outputs are compared.
  task automatic tick();
    bit [N-1:0] pe, cand, ins_n, pend_n, prev_n;
    int thr, w, st_n, num_n;
    bit elig, ok;
    if (I_reset) begin
      ins_n = '0; pend_n = '0; prev_n = '0; st_n = MIdle; num_n = 0;
    end else begin
      thr = NEST ? lowest(m_ins) : ((m_ins != 0) ? 0 : N);
      for (int i = 0; i < N; i++) pe[i] = I_edge_mode[i] ? m_pend[i] : I_irq[i];
      cand = pe & I_mask & ~m_ins;
      w    = lowest(cand);
      elig = I_irq_enabled && (w < thr);
      ok   = I_irq_enabled && pe[m_num] && I_mask[m_num] && !m_ins[m_num] && (m_num < thr);
      ins_n = m_ins;
      if (I_eoi && m_ins != 0) ins_n[lowest(m_ins)] = 1'b0;
      pend_n = m_pend;
      st_n   = m_state;
      num_n  = m_num;
      case (m_state)
        MIdle: if (elig) begin st_n = MReq; num_n = w; end
        MReq: begin
          if (I_ack) begin
            ins_n[m_num]  = 1'b1;
            pend_n[m_num] = 1'b0;
            st_n          = MSvc;
          end else if (!ok) begin
            st_n = MIdle;
          end
        end
        default: begin
          if (I_eoi && (!NEST || ins_n == 0)) st_n = MIdle;
          else if (NEST && elig) begin st_n = MReq; num_n = w; end
        end
      endcase
      pend_n = pend_n | (I_edge_mode & I_irq & ~m_prev);
      prev_n = I_irq;
    end
    @(posedge I_clk);
    m_pend = pend_n; m_prev = prev_n; m_ins = ins_n; m_state = st_n; m_num = num_n;
    m_act  = (st_n == MReq);
    #1;
    check_eq("active", 32'(O_irq_active), 32'(m_act));
    check_eq("number", 32'(O_irq_number), 32'(m_num));
    check_eq("vector", 32'(O_vector), 32'((BASE + m_num * STRIDE) % 65536));
    check_eq("in_service", 32'(O_in_service), 32'(m_ins));
  endtask

  task automatic do_reset();
    I_reset = 1'b1; I_irq = '0; I_ack = 1'b0; I_eoi = 1'b0;
    tick();
    I_reset = 1'b0;
  endtask

  task automatic pulse_ack();
    I_ack = 1'b1; tick(); I_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    I_eoi = 1'b1; tick(); I_eoi = 1'b0;
  endtask

  initial begin
    I_edge_mode = 8'hFF; I_mask = 8'hFF; I_irq_enabled = 1'b1;
    do_reset();
    check_eq("rst_active", 32'(O_irq_active), 32'd0);
    check_eq("rst_vector", 32'(O_vector), 32'h0064);
    check_eq("rst_number", 32'(O_irq_number), 32'd0);

    // Edge on ch3: two-cycle latency
    tick();
    I_irq = 8'h08; tick();
    check_eq("edge_lat_t1", 32'(O_irq_active), 32'd0);
    I_irq = 8'h00; tick();
    check_eq("ch3_active", 32'(O_irq_active), 32'd1);
    check_eq("ch3_number", 32'(O_irq_number), 32'd3);
    check_eq("ch3_vector", 32'(O_vector), 32'h006A);
    pulse_ack();
    check_eq("ch3_ins", 32'(O_in_service), 32'h08);
    check_eq("ch3_ack_drop", 32'(O_irq_active), 32'd0);
    pulse_eoi();
    check_eq("ch3_eoi", 32'(O_in_service), 32'h00);

    // Simultaneous edges on ch5 and ch1
    do_reset();
    I_irq = 8'h22; tick(); I_irq = 8'h00; tick();
    check_eq("prio_vec1", 32'(O_vector), 32'h0066);
    pulse_ack(); pulse_eoi(); tick();
    check_eq("prio_num5", 32'(O_irq_number), 32'd5);
    check_eq("prio_vec5", 32'(O_vector), 32'h006E);

    // Nesting behaviour with ch4 in service
    do_reset();
    I_irq = 8'h10; tick(); I_irq = 8'h00; tick(); pulse_ack();
`ifdef IRQ_NESTING_EN
    I_irq = 8'h04; tick(); I_irq = 8'h00; tick();
    check_eq("nest_req2", 32'(O_irq_number), 32'd2);
    pulse_ack();
    check_eq("nest_ins", 32'(O_in_service), 32'h14);
    I_irq = 8'h40; tick(); I_irq = 8'h00; tick();
    check_eq("nest_ch6_held", 32'(O_irq_active), 32'd0);
    pulse_eoi();
    check_eq("nest_ch6_held2", 32'(O_irq_active), 32'd0);
    pulse_eoi(); tick();
    check_eq("nest_ch6_req", 32'(O_irq_number), 32'd6);
`else
    I_irq = 8'h01; tick(); I_irq = 8'h00; tick(); tick();
    check_eq("nonest_blocked", 32'(O_irq_active), 32'd0);
    pulse_eoi();
    check_eq("nonest_eoi", 32'(O_in_service), 32'h00);
    tick();
    check_eq("nonest_ch0", 32'(O_irq_active), 32'd1);
    check_eq("nonest_ch0n", 32'(O_irq_number), 32'd0);
`endif

    // Level ch7 held through EOI, then masked in REQ
    do_reset();
    I_edge_mode = 8'h7F; I_irq = 8'h80; tick();
    check_eq("lvl_lat", 32'(O_irq_active), 32'd1);
    pulse_ack(); pulse_eoi();
    check_eq("lvl_eoi_idle", 32'(O_irq_active), 32'd0);
    tick();
    check_eq("lvl_rereq", 32'(O_irq_active), 32'd1);
    I_mask = 8'h7F; tick();
    check_eq("lvl_mask_drop", 32'(O_irq_active), 32'd0);
    I_mask = 8'hFF; I_irq = 8'h00; I_edge_mode = 8'hFF;

    // Reset while presenting ch2
    do_reset();
    I_irq = 8'h04; tick(); tick();
    check_eq("pre_rst_req", 32'(O_irq_number), 32'd2);
    do_reset();
    check_eq("rst_req_vec", 32'(O_vector), 32'h0064);
    check_eq("rst_req_act", 32'(O_irq_active), 32'd0);
    repeat (3) tick();
    check_eq("rst_no_req", 32'(O_irq_active), 32'd0);

    // Randomized traffic
    for (int seg = 0; seg < 20; seg++) begin
      do_reset();
      I_edge_mode = N'($urandom);
      I_mask      = N'($urandom | $urandom);
      for (int c = 0; c < 150; c++) begin
        I_irq         = I_irq ^ N'($urandom & $urandom & $urandom);
        I_irq_enabled = ($urandom_range(0, 15) != 0);
        I_ack         = (m_state == MReq) ? 1'($urandom) : ($urandom_range(0, 9) == 0);
        I_eoi         = ($urandom_range(0, 5) == 0);
        if (c % 16 == 15) I_mask = N'($urandom | $urandom);
        tick();
      end
      I_ack = 1'b0; I_eoi = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller placed between external interrupt sources and the core's control unit. It replaces the core's single-line `I_irq_active` / fixed irq-number read with N prioritised channels, per-channel edge or level sensing, masking and an in-service tracker. It delivers a registered request, channel number and ISR vector address to the control unit, and retires interrupts on end-of-interrupt (RETI).

## Interface
Parameters:
- NUM_IRQ, 8, number of channels, legal range 2..16; channel 0 has the highest priority.
- VECTOR_BASE, 16'h0064, address of the channel-0 vector.
- VECTOR_STRIDE, 2, byte distance between consecutive vectors.
- IDW, $clog2(NUM_IRQ), width of the channel-number output (derived, not overridden).

Ports:
- Reset is I_reset, synchronous, active-high; the clock is I_clk.
- I_clk  in  1  clock.
- I_reset  in  1  synchronous, active-high reset.
- I_irq  in  NUM_IRQ  raw request lines, synchronous to I_clk.
- I_edge_mode  in  NUM_IRQ  per channel: 1 = rising-edge latched, 0 = level.
- I_mask  in  NUM_IRQ  per-channel enable; 1 = enabled.
- I_irq_enabled  in  1  global enable from the ALU interrupt flag.
- I_ack  in  1  control unit accepts the presented interrupt (enters ISR).
- I_eoi  in  1  end of interrupt; one-cycle pulse on RETI.
- O_irq_active  out  1  interrupt request to the control unit.
- O_irq_number  out  IDW  channel being presented.
- O_vector  out  16  ISR entry address.
- O_in_service  out  NUM_IRQ  channels currently in service.

## Operation
- Edge channels:
  - A registered copy of I_irq, prev, is kept.
  - A pending bit is set when I_irq=1 and prev=0.
  - The pending bit is cleared when that channel is acked.
  - If set and clear occur in the same cycle, set wins.
- Level channels: pending equals I_irq; it is never latched.
- Candidate set = pending & I_mask & ~in_service. The winner is the lowest-index candidate.
- Eligible = I_irq_enabled && candidate set non-empty && winner index < threshold.
  - Threshold is the lowest in-service index, or NUM_IRQ if none are in service (nesting on).
  - See Configuration for nesting off.
- States:
  - IDLE: on eligible, go to REQ and register the number and vector.
  - REQ:
    - O_irq_active=1; number and vector are frozen.
    - On I_ack: set in_service[number], clear the edge pending bit, go to SERVICE.
    - If not eligible for the frozen channel (mask cleared, global disable, or outranked under nesting) and no I_ack: go to IDLE. An edge pending bit is retained.
  - SERVICE:
    - O_irq_active=0.
    - On I_eoi, clear the lowest-index set in_service bit. If none remain, go to IDLE.
    - With nesting on, an eligible winner moves the block to REQ; in_service is kept.
- Vector = VECTOR_BASE + number*VECTOR_STRIDE, computed in 16 bits with wrap-around modulo 2^16.
- Ignored events:
  - I_ack outside REQ.
  - I_eoi with in_service==0.
- I_eoi and I_ack in the same cycle: apply the eoi clear first, then the ack set.
- Reset: pending=0, prev=0, in_service=0, state=IDLE, O_irq_active=0, O_irq_number=0, O_vector=VECTOR_BASE.

## Timing
- Edge latency: rising I_irq sampled at edge t → pending at t+1 → O_irq_active high at t+2.
- Level latency: I_irq sampled at t → O_irq_active high at t+1.
- All outputs are registered; there is no combinational path from any input to any output.
- O_irq_number and O_vector are valid in the same cycle as O_irq_active and stay stable while it is high.
- I_ack sampled in REQ → O_irq_active low the next cycle, and O_in_service updates that same next cycle.
- Re-request: a new request can be raised at the earliest 1 cycle after leaving SERVICE or after the I_eoi update.
- Level sources must be cleared by the ISR before RETI. Otherwise the channel re-requests 1 cycle after EOI.

## Configuration
- IRQ_NESTING_EN defined:
  - A strictly higher-priority channel preempts an in-service one.
  - O_in_service can hold several bits.
  - EOI retires the highest-priority in-service channel.
- IRQ_NESTING_EN undefined:
  - At most one channel is in service.
  - Threshold is 0 whenever in_service != 0, so no request is raised in SERVICE.
  - I_eoi always returns the block to IDLE.

## Test plan
- Edge on ch3 (edge mode, mask=8'hFF, enabled) → O_irq_active at t+2, O_irq_number=3, O_vector=16'h006A. After I_ack: O_in_service=8'h08. After I_eoi: 8'h00.
- Edges on ch5 and ch1 in the same cycle → ch1 presented first (vector 16'h0066). After ack+eoi of ch1 → ch5 presented (16'h006E).
- Nesting on: ch4 in service, edge on ch2 → request ch2, O_in_service=8'h14 after ack. Edge on ch6 while ch4 is in service → no request until both EOIs complete.
- Nesting off: ch4 in service, edge on ch0 → O_irq_active stays 0. After I_eoi → ch0 presented 1 cycle later.
- Level ch7 held high through EOI → re-request 1 cycle after EOI. Clear I_mask[7] while in REQ → O_irq_active drops next cycle, state IDLE.
- I_reset asserted in REQ with ch2 pending → next cycle all outputs at reset values, O_vector=16'h0064, no request without a new edge.
